// File: rtl/arg_value_parser_pkg.sv
// Character classes shared by the argument parser and its character reader.
// A class code is either one of the CHAR_* constants below or, for letters,
// the upper-case ASCII code of the letter itself, so a title letter can be
// compared directly against the class of the character just read.
package Char_PKG;

  typedef logic [7:0] Char_t;

  localparam Char_t CHAR_NEWLINE    = 8'h0A;
  localparam Char_t CHAR_WHITESPACE = 8'h20;
  localparam Char_t CHAR_MINUS      = 8'h2D;
  localparam Char_t CHAR_DOT        = 8'h2E;
  localparam Char_t CHAR_NUM        = 8'h30;
  localparam Char_t CHAR_OTHER      = 8'h3F;

  // A number ends cleanly on a blank or at the end of the line.
  function automatic logic is_terminator(input Char_t c);
    return (c == CHAR_WHITESPACE) || (c == CHAR_NEWLINE);
  endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Multiply-by-ten-and-add datapath for the decimal parser.
// The result saturates at the largest positive value representable in a
// NUM_BITS-wide signed number, and ovf reports that saturation happened.
module decimal_accumulator #(
  parameter int NUM_BITS = 16
) (
  input  logic [NUM_BITS+3:0] mag,
  input  logic [3:0]          digit,
  input  logic                mul_only,
  output logic [NUM_BITS+3:0] next_mag,
  output logic                ovf
);

  localparam int ACC_W  = NUM_BITS + 4;
  localparam int WIDE_W = ACC_W + 4;

  localparam logic [ACC_W-1:0] MAX_MAG =
    {{(ACC_W - NUM_BITS + 1){1'b0}}, {(NUM_BITS - 1){1'b1}}};

  logic [WIDE_W-1:0] wide_mag;
  logic [WIDE_W-1:0] times_ten;
  logic [WIDE_W-1:0] addend;

  // mag*10 is built as mag*8 + mag*2 in a width that cannot wrap, then clamped.
  always_comb begin
    wide_mag  = {4'b0000, mag};
    times_ten = (wide_mag << 3) + (wide_mag << 1);
    addend    = {{(WIDE_W - 4){1'b0}}, (mul_only ? 4'd0 : digit)};
    ovf       = (times_ten + addend) > {4'b0000, MAX_MAG};
    next_mag  = ovf ? MAX_MAG : times_ten[ACC_W-1:0] + addend[ACC_W-1:0];
  end

endmodule

// File: rtl/arg_value_parser.sv
// Searches a character stream for a titled argument such as "X-12.5" and
// converts the number that follows into a signed fixed-point value scaled
// by 10^FRAC_DIGITS. Characters are fetched one at a time from an external
// reader through a rdy/trigger/done handshake.
module arg_value_parser
  import Char_PKG::*;
#(
  parameter int NUM_BITS    = 16,
  parameter int FRAC_DIGITS = 2,
  parameter int ROUND_EN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                trigger,
  input  Char_t               arg_title,
  input  Char_t               char_type,
  input  logic [3:0]          char_val,
  input  logic                rd_rdy,
  input  logic                rd_done,
  input  logic                is_empty,
  output logic                rd_trigger,
  output logic                rdy,
  output logic                done,
  output logic [NUM_BITS-1:0] value,
  output logic                found,
  output logic                success,
  output logic                too_big,
  output logic                term_newline
);

  localparam int ACC_W = NUM_BITS + 4;
  localparam int FC_W  = (FRAC_DIGITS > 0) ? $clog2(FRAC_DIGITS + 1) : 1;

  localparam logic [ACC_W-1:0] MAX_MAG =
    {{(ACC_W - NUM_BITS + 1){1'b0}}, {(NUM_BITS - 1){1'b1}}};
  localparam logic [FC_W-1:0] FRAC_FULL = FC_W'(FRAC_DIGITS);

  // Each fetch phase occupies four consecutive codes so that the handshake
  // steps can advance with a simple increment.
  typedef enum logic [4:0] {
    S_IDLE,
    S_TITLE_WAIT_RDY, S_TITLE_TRIGGER, S_TITLE_WAIT_DONE, S_TITLE_CHECK,
    S_SIGN_WAIT_RDY,  S_SIGN_TRIGGER,  S_SIGN_WAIT_DONE,  S_SIGN_CHECK,
    S_INT_WAIT_RDY,   S_INT_TRIGGER,   S_INT_WAIT_DONE,   S_INT_CHECK,
    S_FRAC_WAIT_RDY,  S_FRAC_TRIGGER,  S_FRAC_WAIT_DONE,  S_FRAC_CHECK,
    S_EXTRA_WAIT_RDY, S_EXTRA_TRIGGER, S_EXTRA_WAIT_DONE, S_EXTRA_CHECK,
    S_SCALE,
    S_ROUND,
    S_FINISH,
    S_DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] mag;
  logic [FC_W-1:0]  frac_cnt;
  logic             neg;
  logic             round_up;

  logic [ACC_W-1:0] acc_next;
  logic             acc_ovf;
  logic             scaling;
  logic             char_is_digit;
  logic             char_is_term;
  logic             frac_complete;

  // SCALE appends an implied zero digit; every other use adds char_val.
  always_comb begin
    scaling       = (state == S_SCALE);
    char_is_digit = (char_type == CHAR_NUM);
    char_is_term  = is_terminator(char_type);
    frac_complete = (frac_cnt == FRAC_FULL);
  end

  decimal_accumulator #(
    .NUM_BITS (NUM_BITS)
  ) u_accumulator (
    .mag      (mag),
    .digit    (char_val),
    .mul_only (scaling),
    .next_mag (acc_next),
    .ovf      (acc_ovf)
  );

  // Parser FSM: drives the reader handshake, accumulates digits and holds results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      mag          <= '0;
      frac_cnt     <= '0;
      neg          <= 1'b0;
      round_up     <= 1'b0;
      rd_trigger   <= 1'b0;
      rdy          <= 1'b1;
      done         <= 1'b1;
      value        <= '0;
      found        <= 1'b0;
      success      <= 1'b0;
      too_big      <= 1'b0;
      term_newline <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            mag          <= '0;
            frac_cnt     <= '0;
            neg          <= 1'b0;
            round_up     <= 1'b0;
            value        <= '0;
            found        <= 1'b0;
            success      <= 1'b0;
            too_big      <= 1'b0;
            term_newline <= 1'b0;
            rdy          <= 1'b0;
            done         <= 1'b0;
            state        <= S_TITLE_WAIT_RDY;
          end
        end

        S_TITLE_WAIT_RDY, S_SIGN_WAIT_RDY, S_INT_WAIT_RDY,
        S_FRAC_WAIT_RDY, S_EXTRA_WAIT_RDY: begin
          if (rd_rdy && !is_empty) begin
            rd_trigger <= 1'b1;
            state      <= state_t'(state + 5'd1);
          end
        end

        S_TITLE_TRIGGER, S_SIGN_TRIGGER, S_INT_TRIGGER,
        S_FRAC_TRIGGER, S_EXTRA_TRIGGER: begin
          if (!rd_rdy) begin
            rd_trigger <= 1'b0;
            state      <= state_t'(state + 5'd1);
          end
        end

        S_TITLE_WAIT_DONE, S_SIGN_WAIT_DONE, S_INT_WAIT_DONE,
        S_FRAC_WAIT_DONE, S_EXTRA_WAIT_DONE: begin
          if (rd_done) begin
            state <= state_t'(state + 5'd1);
          end
        end

        S_TITLE_CHECK: begin
          if (char_type == arg_title) begin
            found <= 1'b1;
            state <= S_SIGN_WAIT_RDY;
          end else if (char_type == CHAR_NEWLINE) begin
            term_newline <= 1'b1;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_TITLE_WAIT_RDY;
          end
        end

        S_SIGN_CHECK: begin
          if (char_type == CHAR_WHITESPACE) begin
            state <= S_SIGN_WAIT_RDY;
          end else if (char_type == CHAR_MINUS) begin
            neg   <= 1'b1;
            state <= S_INT_WAIT_RDY;
          end else if (char_type == CHAR_DOT) begin
            state <= S_FRAC_WAIT_RDY;
          end else if (char_is_digit) begin
            mag <= acc_next;
            if (acc_ovf) too_big <= 1'b1;
            state <= S_INT_WAIT_RDY;
          end else begin
            if (char_type == CHAR_NEWLINE) term_newline <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_INT_CHECK: begin
          if (char_is_digit) begin
            mag <= acc_next;
            if (acc_ovf) too_big <= 1'b1;
            state <= S_INT_WAIT_RDY;
          end else if (char_type == CHAR_DOT) begin
            state <= S_FRAC_WAIT_RDY;
          end else if (char_is_term) begin
            if (char_type == CHAR_NEWLINE) term_newline <= 1'b1;
            state <= frac_complete ? S_ROUND : S_SCALE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_FRAC_CHECK: begin
          if (char_is_digit && !frac_complete) begin
            mag      <= acc_next;
            frac_cnt <= frac_cnt + FC_W'(1);
            if (acc_ovf) too_big <= 1'b1;
            state <= S_FRAC_WAIT_RDY;
          end else if (char_is_digit) begin
            round_up <= (ROUND_EN != 0) && (char_val >= 4'd5);
            state    <= S_EXTRA_WAIT_RDY;
          end else if (char_is_term) begin
            if (char_type == CHAR_NEWLINE) term_newline <= 1'b1;
            state <= frac_complete ? S_ROUND : S_SCALE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_EXTRA_CHECK: begin
          if (char_is_digit) begin
            state <= S_EXTRA_WAIT_RDY;
          end else if (char_is_term) begin
            if (char_type == CHAR_NEWLINE) term_newline <= 1'b1;
            state <= frac_complete ? S_ROUND : S_SCALE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_SCALE: begin
          mag      <= acc_next;
          frac_cnt <= frac_cnt + FC_W'(1);
          if (acc_ovf) too_big <= 1'b1;
          if ((frac_cnt + FC_W'(1)) == FRAC_FULL) begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (round_up) begin
            if (mag >= MAX_MAG) begin
              mag     <= MAX_MAG;
              too_big <= 1'b1;
            end else begin
              mag <= mag + ACC_W'(1);
            end
          end
          state <= S_FINISH;
        end

        S_FINISH: begin
          value   <= neg ? (~mag[NUM_BITS-1:0] + NUM_BITS'(1)) : mag[NUM_BITS-1:0];
          success <= 1'b1;
          done    <= 1'b1;
          state   <= S_DONE;
        end

        S_DONE: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          rd_trigger <= 1'b0;
          rdy        <= 1'b1;
          done       <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/arg_value_parser.md
ARG_VALUE_PARSER -- requirements
Module: arg_value_parser

Interface
REQ-001 Parameter NUM_BITS, default 16, width of the signed fixed-point result.
REQ-002 Parameter FRAC_DIGITS, default 2, decimal fraction digits kept; result = parsed value x 10^FRAC_DIGITS.
REQ-003 Parameter ROUND_EN, default 1, 1 = round half-up on the first dropped fraction digit, 0 = truncate.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  reset is asynchronous and active-high.
REQ-006 clk_en  in  1  state, accumulator and flag updates occur only when high.
REQ-007 trigger  in  1  start parse; sampled in IDLE only.
REQ-008 arg_title  in  Char_t  argument letter to search for.
REQ-009 char_type  in  Char_t  class of the last read character; valid when rd_done.
REQ-010 char_val  in  4  digit value of the last read character; meaningful when char_type == CHAR_NUM.
REQ-011 rd_rdy, rd_done, is_empty  in  1 each  character-reader status.
REQ-012 rd_trigger  out  1  character read request.
REQ-013 rdy  out  1  high in IDLE only.
REQ-014 done  out  1  high in IDLE and DONE.
REQ-015 value  out  NUM_BITS  signed result, held until next trigger.
REQ-016 found, success, too_big, term_newline  out  1 each  result flags, held until next trigger.

Function
REQ-017 Every character fetch SHALL use: WAIT_RDY (until rd_rdy & !is_empty) -> TRIGGER (rd_trigger=1 until rd_rdy=0) -> WAIT_DONE (until rd_done) -> CHECK (char_type sampled).
REQ-018 Phases: TITLE, SIGN, INT, FRAC, EXTRA, each with the four fetch states; plus SCALE, ROUND, FINISH, DONE, IDLE.
REQ-019 IDLE + trigger: clear accumulator, frac_cnt, neg, round_up and all flags; go TITLE_WAIT_RDY.
REQ-020 TITLE_CHECK: arg_title -> found=1, SIGN; CHAR_NEWLINE -> term_newline=1, DONE; else next TITLE fetch.
REQ-021 SIGN_CHECK: whitespace -> next SIGN fetch; minus -> neg=1, INT fetch; dot -> FRAC fetch; digit -> accumulate, INT fetch; else DONE, success=0.
REQ-022 INT_CHECK: digit -> mag = mag*10 + char_val; dot -> FRAC; whitespace/newline -> SCALE; else DONE, success=0.
REQ-023 FRAC_CHECK: digit with frac_cnt < FRAC_DIGITS -> accumulate, frac_cnt+1; digit with frac_cnt == FRAC_DIGITS -> round_up = ROUND_EN & (char_val >= 5), EXTRA; whitespace/newline -> SCALE; else DONE, success=0.
REQ-024 EXTRA_CHECK: digits consumed and discarded; whitespace/newline -> SCALE; else DONE, success=0.
REQ-025 Any terminating CHAR_NEWLINE SHALL set term_newline=1.
REQ-026 Accumulator SHALL be NUM_BITS+4 bits unsigned; MAX_MAG = 2^(NUM_BITS-1)-1; any mag > MAX_MAG sets too_big=1 and clamps mag to MAX_MAG; parsing continues to terminator.
REQ-027 SCALE: one cycle per missing fraction digit (mag*=10, frac_cnt+1, clamped per REQ-026) until frac_cnt == FRAC_DIGITS.
REQ-028 ROUND: one cycle; if round_up, mag+1 with clamp.
REQ-029 FINISH: value = neg ? -mag : mag; success=1; -> DONE.
REQ-030 DONE: one cycle, done=1, -> IDLE.
REQ-031 Latency from last rd_done to done: CHECK + (FRAC_DIGITS - frac_cnt) SCALE + ROUND + FINISH + DONE cycles, clk_en continuously high.
REQ-032 "-0" SHALL yield value 0, success=1.

Reset
REQ-033 reset SHALL immediately force IDLE, value=0, found=success=too_big=term_newline=0, rd_trigger=0, rdy=1, done=1, regardless of clk_en or current state.
REQ-034 Reset mid-fetch SHALL abandon the read without further rd_trigger.

Structure
REQ-035 Char_t and CHAR_* constants SHALL come from Char_PKG; state enum is module-local.
REQ-036 The multiply-add-clamp datapath SHALL be a sub-module decimal_accumulator (NUM_BITS parameter, inputs mag, digit, mul_only; outputs next_mag, ovf).

Verification (NUM_BITS=16, FRAC_DIGITS=2, ROUND_EN=1)
REQ-037 "X-12.5 " title X -> value -1250, found=1, success=1, too_big=0, term_newline=0.
REQ-038 "Y3 X7\n" title X -> value 700, found=1, success=1, term_newline=1.
REQ-039 "G1\n" title X -> found=0, success=0, term_newline=1, value 0.
REQ-040 "X400 " -> value 32767, too_big=1, success=1; "X-400 " -> -32767.
REQ-041 "X1.236 " -> 124; "X.5\n" -> 50; ROUND_EN=0 "X1.236 " -> 123; "X1a" -> success=0.
REQ-042 reset asserted during INT_WAIT_DONE, clk_en=0 -> all outputs at reset values same cycle; new trigger parses "X2 " -> 200.
